id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode stage of the 5-stage MIPS pipeline, wrapped around the register file.
//  Owns the IF/ID latch and drives the register-file read addresses.
//  Captures the register-file read data, detects load-use hazards, and produces the ID/EX pipeline register.
//  Sits between instruction fetch and the EX/ALU stage.
// PARAMETERS
//  (none: widths fixed by MIPS32, XLEN=32, 5-bit register indices)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   asynchronous, active-high reset
//  if_valid      in   1   fetch presents an instruction
//  if_instr      in   32  instruction word
//  if_pc         in   32  PC of if_instr
//  id_ready      out  1   ID accepts if_* this cycle (0 = fetch must hold)
//  readReg1      out  5   rs field of held instr -> register file
//  readReg2      out  5   rt field of held instr -> register file
//  reg1Data      in   32  register file rs data (combinational, $0 reads 0)
//  reg2Data      in   32  register file rt data
//  wb_write      in   1   writeback writes register file this cycle
//  wb_reg        in   5   writeback destination
//  wb_data       in   32  writeback data
//  ex_stall      in   1   EX cannot advance; hold whole stage
//  flush         in   1   taken branch/jump resolved in EX; kill ID and EX
//  ex_valid      out  1   ID/EX register holds a live instruction
//  ex_pc         out  32  PC
//  ex_op         out  6   opcode [31:26]
//  ex_funct      out  6   funct [5:0]
//  ex_rs_data    out  32  rs operand
//  ex_rt_data    out  32  rt operand
//  ex_imm        out  32  extended immediate
//  ex_dest       out  5   destination register (0 = none)
//  ex_mem_read   out  1   instruction is lw
//  ex_reg_write  out  1   instruction writes a register
// BEHAVIOUR
//  - Reset: id_valid=0, id_instr=0, id_pc=0.
//    All ex_* outputs 0 (ex_valid=0, ex_dest=0, ex_mem_read=0, ex_reg_write=0).
//    id_ready=1 once rst deasserts.
//  - Decode:
//    op=0x00: dest=rd, write=1; funct 0x08 (jr): dest=0, write=0.
//    op=0x23 lw: dest=rt, mem_read=1, write=1.
//    op=0x2B sw, 0x04 beq, 0x05 bne: dest=0, write=0.
//    op 0x08/0x0A/0x0C/0x0D/0x0F: dest=rt, write=1.
//    Unknown opcode: dest=0, write=0, still passed as valid.
//  - Immediate: zero-extend for 0x0C/0x0D; sign-extend instr[15:0] otherwise.
//  - uses_rt = op in {0x00, 0x2B, 0x04, 0x05}.
//  - Load-use hazard: ex_valid & ex_mem_read & ex_dest!=0 &
//    (ex_dest==rs | (uses_rt & ex_dest==rt)) & id_valid.
//  - Per-edge priority:
//    1. rst
//    2. flush: id_valid<=0, ex_valid<=0
//    3. ex_stall: hold both registers
//    4. hazard: hold ID, load bubble (ex_valid<=0, ex_dest<=0, write/mem_read<=0)
//    5. normal: ID->EX, if_*->ID (id_valid<=if_valid)
//  - id_ready = ~hazard & ~ex_stall (combinational); flush forces id_ready=1.
//    if_* are discarded on flush.
//  - Latency: an instruction accepted at edge N appears on ex_* after edge N+1, if unstalled.
//  - Hazard stall lasts exactly 1 cycle: the bubble removes the lw from EX.
//  - Bubbles and invalid slots carry ex_reg_write=0 and ex_mem_read=0.
// CONFIGURATION
//  ID_WB_BYPASS_EN defined:
//    if wb_write & wb_reg!=0 & wb_reg==rs, ex_rs_data<=wb_data (same rule for rt).
//    Covers a register-file write and read in the same cycle.
//  Undefined:
//    operands taken raw from reg1Data/reg2Data.
//    The same-cycle WB read returns the old value; the compiler must schedule around it.
// TESTING
//  1. rst high mid-run -> all ex_* = 0 immediately, id_ready=1 after release.
//  2. addi $1,$0,5 (0x20010005) -> next cycle ex_dest=1, ex_imm=5, ex_reg_write=1.
//     ori imm 0xFFFF -> ex_imm=0x0000FFFF; addi imm 0xFFFF -> ex_imm=0xFFFFFFFF.
//  3. lw $2,0($1) then add $3,$2,$2 ->
//     id_ready=0 for 1 cycle, one bubble (ex_valid=0), then add issues with ex_dest=3.
//  4. lw $2 then add $3,$4,$5 -> no stall.
//     lw $0 then use $0 -> no stall.
//  5. flush together with hazard and ex_stall ->
//     ex_valid=0 and ID empty next cycle; fetch not held.
//  6. ID_WB_BYPASS_EN: wb_write=1, wb_reg=rs=7, wb_data=0xDEADBEEF, reg1Data=0 ->
//     ex_rs_data=0xDEADBEEF.
//     Without the macro -> ex_rs_data=0.
//     wb_reg=0 -> no bypass in either build.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS decode stage owning the IF/ID and ID/EX registers, with load-use stall and flush.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle register-file writeback into the captured operands.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  output logic [4:0]  readReg1,
  output logic [4:0]  readReg2,
  input  logic [31:0] reg1Data,
  input  logic [31:0] reg2Data,
  input  logic        wb_write,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [5:0]  ex_op,
  output logic [5:0]  ex_funct,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dest,
  output logic        ex_mem_read,
  output logic        ex_reg_write
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic        vld_p0;
  logic [31:0] instr_p0;
  logic [31:0] pc_p0;

  logic [5:0]  op_p0;
  logic [5:0]  funct_p0;
  logic [4:0]  rs_p0;
  logic [4:0]  rt_p0;
  logic [4:0]  rd_p0;
  logic [4:0]  dest_p0;
  logic        write_p0;
  logic        uses_rt_p0;
  logic [31:0] imm_p0;
  logic [31:0] rs_val_p0;
  logic [31:0] rt_val_p0;
  logic        hazard;

  // Logical ops take an unsigned immediate; everything else sign-extends.
  function automatic logic [31:0] ext_imm(input logic [5:0] opc, input logic [15:0] raw);
    logic signed [15:0] simm;
    simm = signed'(raw);
    if (opc == OP_ANDI || opc == OP_ORI) return {16'h0000, raw};
    return 32'(simm);
  endfunction

  assign op_p0    = instr_p0[31:26];
  assign rs_p0    = instr_p0[25:21];
  assign rt_p0    = instr_p0[20:16];
  assign rd_p0    = instr_p0[15:11];
  assign funct_p0 = instr_p0[5:0];
  assign imm_p0   = ext_imm(op_p0, instr_p0[15:0]);

  assign readReg1 = rs_p0;
  assign readReg2 = rt_p0;

  always_comb begin
    dest_p0  = 5'd0;
    write_p0 = 1'b0;
    case (op_p0)
      OP_RTYPE: begin
        if (funct_p0 != FN_JR) begin
          dest_p0  = rd_p0;
          write_p0 = 1'b1;
        end
      end
      OP_LW, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        dest_p0  = rt_p0;
        write_p0 = 1'b1;
      end
      default: begin
        dest_p0  = 5'd0;
        write_p0 = 1'b0;
      end
    endcase
  end

  assign uses_rt_p0 = (op_p0 == OP_RTYPE) || (op_p0 == OP_SW) ||
                      (op_p0 == OP_BEQ)   || (op_p0 == OP_BNE);

`ifdef ID_WB_BYPASS_EN
  function automatic logic [31:0] bypass(input logic [4:0] idx, input logic [31:0] rf_val,
                                         input logic w, input logic [4:0] r, input logic [31:0] d);
    if (w && r != 5'd0 && r == idx) return d;
    return rf_val;
  endfunction

  assign rs_val_p0 = bypass(rs_p0, reg1Data, wb_write, wb_reg, wb_data);
  assign rt_val_p0 = bypass(rt_p0, reg2Data, wb_write, wb_reg, wb_data);
`else
  // Without the bypass the register file's old value is used; writeback is ignored here.
  logic unused_wb;
  assign unused_wb = ^{wb_write, wb_reg, wb_data};
  assign rs_val_p0 = reg1Data;
  assign rt_val_p0 = reg2Data;
`endif

  assign hazard = vld_p0 & ex_valid & ex_mem_read & (ex_dest != 5'd0) &
                  ((ex_dest == rs_p0) | (uses_rt_p0 & (ex_dest == rt_p0)));

  assign id_ready = flush | (~hazard & ~ex_stall);

  // IF -> ID boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      instr_p0 <= 32'd0;
      pc_p0    <= 32'd0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (!ex_stall && !hazard) begin
      vld_p0   <= if_valid;
      instr_p0 <= if_instr;
      pc_p0    <= if_pc;
    end
  end

  // ID -> EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= 32'd0;
      ex_op        <= 6'd0;
      ex_funct     <= 6'd0;
      ex_rs_data   <= 32'd0;
      ex_rt_data   <= 32'd0;
      ex_imm       <= 32'd0;
      ex_dest      <= 5'd0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else if (flush || (!ex_stall && hazard)) begin
      ex_valid     <= 1'b0;
      ex_dest      <= 5'd0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid     <= vld_p0;
      ex_pc        <= pc_p0;
      ex_op        <= op_p0;
      ex_funct     <= funct_p0;
      ex_rs_data   <= rs_val_p0;
      ex_rt_data   <= rt_val_p0;
      ex_imm       <= imm_p0;
      ex_dest      <= vld_p0 ? dest_p0 : 5'd0;
      ex_mem_read  <= vld_p0 & (op_p0 == OP_LW);
      ex_reg_write <= vld_p0 & write_p0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage: a queue-based pipeline model predicts every EX-stage output.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = 32'd0;
  logic [31:0] if_pc = 32'd0;
  logic        id_ready;
  logic [4:0]  readReg1, readReg2;
  logic [31:0] reg1Data, reg2Data;
  logic        wb_write = 1'b0;
  logic [4:0]  wb_reg = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        ex_stall = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [5:0]  ex_op, ex_funct;
  logic [4:0]  ex_dest;
  logic        ex_mem_read, ex_reg_write;

  logic [31:0] regs [32];
  assign reg1Data = regs[readReg1];
  assign reg2Data = regs[readReg2];

  id_ex_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .readReg1(readReg1), .readReg2(readReg2),
    .reg1Data(reg1Data), .reg2Data(reg2Data),
    .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_funct(ex_funct),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        mr;
    logic        rw;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } slot_t;

  exp_t  exp_q[$];
  slot_t id_q[$];
  exp_t  ex_m, cur;
  logic  exp_live = 1'b0;
  logic  new_ex = 1'b0;
  logic  accepted = 1'b0;
  logic [31:0] pc = 32'h0000_1000;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic uses_rt(input logic [5:0] opc);
    return opc inside {6'h00, 6'h2B, 6'h04, 6'h05};
  endfunction

  function automatic logic [31:0] read_operand(input logic [4:0] idx);
    logic [31:0] v;
    v = regs[idx];
`ifdef ID_WB_BYPASS_EN
    if (wb_write && wb_reg != 5'd0 && wb_reg == idx) v = wb_data;
`endif
    return v;
  endfunction

  // Expected EX contents straight from the decode table, operands as seen on the transfer edge.
  function automatic exp_t ref_exp(input logic [31:0] ins, input logic [31:0] ipc);
    exp_t r;
    logic [5:0] opc;
    opc = ins[31:26];
    r.pc = ipc; r.op = opc; r.funct = ins[5:0];
    r.a = read_operand(ins[25:21]);
    r.b = read_operand(ins[20:16]);
    r.dest = 5'd0; r.mr = 1'b0; r.rw = 1'b0;
    if (opc == 6'h00) begin
      if (ins[5:0] != 6'h08) begin r.dest = ins[15:11]; r.rw = 1'b1; end
    end else if (opc == 6'h23) begin
      r.dest = ins[20:16]; r.mr = 1'b1; r.rw = 1'b1;
    end else if (opc inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F}) begin
      r.dest = ins[20:16]; r.rw = 1'b1;
    end
    if (opc == 6'h0C || opc == 6'h0D) r.imm = {16'h0, ins[15:0]};
    else r.imm = {{16{ins[15]}}, ins[15:0]};
    return r;
  endfunction

  // Predicts the coming edge from the inputs now on the pins.
  task automatic model_step();
    logic haz;
    logic [31:0] ins;
    slot_t s;
    new_ex = 1'b0;
    accepted = 1'b0;
    if (rst) begin
      id_q.delete();
      exp_live = 1'b0;
      return;
    end
    haz = 1'b0;
    if (exp_live && ex_m.mr && ex_m.dest != 5'd0 && id_q.size() > 0) begin
      ins = id_q[0].ins;
      haz = (ex_m.dest == ins[25:21]) || (uses_rt(ins[31:26]) && ex_m.dest == ins[20:16]);
    end
    chk("id_ready", 32'(id_ready), 32'(flush || (!haz && !ex_stall)));
    if (flush) begin
      id_q.delete();
      exp_live = 1'b0;
    end else if (ex_stall) begin
      exp_live = exp_live;
    end else if (haz) begin
      exp_live = 1'b0;
    end else begin
      if (id_q.size() > 0) begin
        s = id_q.pop_front();
        ex_m = ref_exp(s.ins, s.pc);
        exp_q.push_back(ex_m);
        new_ex = 1'b1;
        exp_live = 1'b1;
      end else begin
        exp_live = 1'b0;
      end
      if (if_valid) begin
        id_q.push_back('{if_instr, if_pc});
        accepted = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (new_ex) begin
      new_ex = 1'b0;
      if (exp_q.size() == 0) chk("ex_queue_underflow", 32'd1, 32'd0);
      else cur = exp_q.pop_front();
    end
    chk("ex_valid", 32'(ex_valid), 32'(exp_live));
    if (exp_live) begin
      chk("ex_pc", ex_pc, cur.pc);
      chk("ex_op", 32'(ex_op), 32'(cur.op));
      chk("ex_funct", 32'(ex_funct), 32'(cur.funct));
      chk("ex_rs_data", ex_rs_data, cur.a);
      chk("ex_rt_data", ex_rt_data, cur.b);
      chk("ex_imm", ex_imm, cur.imm);
      chk("ex_dest", 32'(ex_dest), 32'(cur.dest));
      chk("ex_mem_read", 32'(ex_mem_read), 32'(cur.mr));
      chk("ex_reg_write", 32'(ex_reg_write), 32'(cur.rw));
    end else begin
      chk("bubble_mem_read", 32'(ex_mem_read), 32'd0);
      chk("bubble_reg_write", 32'(ex_reg_write), 32'd0);
    end
    if (rst) begin
      chk("rst_ex_pc", ex_pc, 32'd0);
      chk("rst_ex_rs_data", ex_rs_data, 32'd0);
      chk("rst_ex_imm", ex_imm, 32'd0);
      chk("rst_ex_dest", 32'(ex_dest), 32'd0);
    end
  end

  task automatic step(input logic r, input logic v, input logic [31:0] ins, input logic st,
                      input logic fl, input logic wbw, input logic [4:0] wr, input logic [31:0] wd);
    @(negedge clk);
    rst = r; if_valid = v; if_instr = ins; if_pc = pc;
    ex_stall = st; flush = fl; wb_write = wbw; wb_reg = wr; wb_data = wd;
    #1;
    if (r) begin
      chk("rst_now_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_now_ex_reg_write", 32'(ex_reg_write), 32'd0);
      chk("rst_now_ex_mem_read", 32'(ex_mem_read), 32'd0);
    end
    #1;
    model_step();
    @(posedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic issue(input logic [31:0] ins, output int tries);
    tries = 0;
    do begin
      step(1'b0, 1'b1, ins, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      tries++;
    end while (!accepted && tries < 10);
    if (!accepted) chk("issue_timeout", 32'd0, 32'd1);
    pc += 32'd4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h3F};
    logic [5:0] opc, fn;
    logic [4:0] rs, rt, rd;
    opc = ops[$urandom_range(0, 10)];
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    fn = ($urandom_range(0, 4) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
    if (opc == 6'h00) return {opc, rs, rt, rd, 5'($urandom_range(0, 31)), fn};
    return {opc, rs, rt, 16'($urandom)};
  endfunction

  initial begin
    int t;
    logic [31:0] cur_ins;
    logic need;
    logic st, fl, wbw, r;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'd0;
    regs[7] = 32'd0;

    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    idle();

    // Immediates and destinations
    issue(32'h2001_0005, t); idle(); #2;
    chk("addi_dest", 32'(ex_dest), 32'd1);
    chk("addi_imm", ex_imm, 32'd5);
    chk("addi_write", 32'(ex_reg_write), 32'd1);
    issue(32'h3401_FFFF, t); idle(); #2;
    chk("ori_imm", ex_imm, 32'h0000_FFFF);
    issue(32'h2001_FFFF, t); idle(); #2;
    chk("addi_neg_imm", ex_imm, 32'hFFFF_FFFF);

    // Load-use: the instruction after the dependent add waits one cycle
    issue(32'h8C22_0000, t);
    issue(32'h0042_1820, t);
    issue(32'h0000_0000, t);
    chk("load_use_tries", 32'(t), 32'd2);
    idle(); idle();
    issue(32'h8C22_0000, t);
    issue(32'h0085_1820, t);
    issue(32'h0000_0000, t);
    chk("no_dep_tries", 32'(t), 32'd1);
    idle(); idle();
    issue(32'h8C20_0000, t);
    issue(32'h0000_1820, t);
    issue(32'h0000_0000, t);
    chk("lw_zero_tries", 32'(t), 32'd1);
    idle(); idle();

    // Flush together with a live hazard and ex_stall
    issue(32'h8C22_0000, t);
    issue(32'h0042_1820, t);
    step(1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0); #2;
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    idle(); #2;
    chk("flush_id_empty", 32'(ex_valid), 32'd0);

    // Writeback bypass into rs
    issue(32'h00E0_1820, t);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF); #2;
`ifdef ID_WB_BYPASS_EN
    chk("bypass_rs", ex_rs_data, 32'hDEAD_BEEF);
`else
    chk("bypass_rs", ex_rs_data, 32'd0);
`endif
    issue(32'h0000_1820, t);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF); #2;
    chk("bypass_r0", ex_rs_data, 32'd0);
    regs[7] = $urandom;

    need = 1'b1;
    cur_ins = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      if (need) cur_ins = rand_instr();
      st  = ($urandom_range(0, 9) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      wbw = ($urandom_range(0, 2) == 0);
      r   = (i >= 1500 && i < 1503);
      step(r, ($urandom_range(0, 9) < 8), cur_ins, st, fl, wbw,
           5'($urandom_range(0, 7)), $urandom);
      need = accepted || fl;
      if (accepted) pc += 32'd4;
    end
    for (int i = 0; i < 4; i++) idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
